// File: rtl/ir_pkg.sv
// ir_pkg: instruction register widths and field types
package ir_pkg;
    localparam int INSTRUCTION_REGISTER = 16;
    localparam int OPCODE_WIDTH = 5;
    typedef logic [INSTRUCTION_REGISTER-1:0] instr_t;
    typedef logic [OPCODE_WIDTH-1:0] opcode_t;
    typedef logic [INSTRUCTION_REGISTER-OPCODE_WIDTH-1:0] operand_t;
endpackage

// File: rtl/instruction_register.sv
// instruction_register: holds the fetched instruction word and exposes its opcode/operand fields
module instruction_register
    import ir_pkg::*;
#(
    parameter int W  = INSTRUCTION_REGISTER,
    parameter int OW = OPCODE_WIDTH
) (
    input  logic          clock,
    input  logic          ir_reset,
    input  logic [W-1:0]  ir_in,
    input  logic          ir_wr,
    output logic [W-1:0]  ir_out,
    output logic [OW-1:0] ir_opcode,
    output logic [W-OW-1:0] ir_operand,
    output logic          ir_valid
);
    logic [W-1:0] ir_q, ir_d;
    logic valid_q, valid_d;
    assign ir_d    = ir_wr ? ir_in : ir_q;
    assign valid_d = ir_wr | valid_q;
    always_ff @(posedge clock or posedge ir_reset) begin
        if (ir_reset) begin
            ir_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            valid_q <= valid_d;
        end
    end
    assign ir_out     = ir_q;
    assign ir_valid   = valid_q;
    assign ir_opcode  = ir_q[W-1 -: OW];
    assign ir_operand = ir_q[W-OW-1:0];
endmodule

// File: tb/tb_instruction_register.sv
// tb_instruction_register: scoreboard bench with a word-level reference model and async reset checks
`timescale 1ns/100ps

module clock_generator (
    output logic clk
);
    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end
endmodule

module tb_instruction_register;
    typedef struct {
        logic [15:0] w;
        logic        v;
    } exp_t;

    logic        clock;
    logic        ir_reset;
    logic [15:0] ir_in;
    logic        ir_wr;
    logic [15:0] ir_out;
    logic [4:0]  ir_opcode;
    logic [10:0] ir_operand;
    logic        ir_valid;

    int checks = 0;
    int fails  = 0;
    exp_t q[$];
    exp_t aq[$];
    event async_ev;
    logic [15:0] model_w = 16'h0;
    logic        model_v = 1'b0;

    clock_generator u_clk (.clk(clock));

    instruction_register dut (
        .clock     (clock),
        .ir_reset  (ir_reset),
        .ir_in     (ir_in),
        .ir_wr     (ir_wr),
        .ir_out    (ir_out),
        .ir_opcode (ir_opcode),
        .ir_operand(ir_operand),
        .ir_valid  (ir_valid)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic compare(input string tag, input exp_t e);
        chk({tag, "_out"}, ir_out, e.w);
        chk({tag, "_valid"}, {15'b0, ir_valid}, {15'b0, e.v});
        chk({tag, "_opcode"}, {11'b0, ir_opcode}, e.w / 16'd2048);
        chk({tag, "_operand"}, {5'b0, ir_operand}, e.w % 16'd2048);
    endtask

    // Applies inputs at a falling edge and predicts what the next rising edge leaves behind.
    task automatic cyc(input logic rst, input logic wr, input logic [15:0] din);
        exp_t e;
        ir_reset = rst;
        ir_wr    = wr;
        ir_in    = din;
        if (rst) begin
            model_w = 16'h0;
            model_v = 1'b0;
            e.w = 16'h0;
            e.v = 1'b0;
            aq.push_back(e);
            ->async_ev;
        end else if (wr) begin
            model_w = din;
            model_v = 1'b1;
        end
        e.w = model_w;
        e.v = model_v;
        q.push_back(e);
        @(negedge clock);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #0.5;
            if (q.size() != 0) compare("edge", q.pop_front());
        end
    end

    initial begin
        forever begin
            @(async_ev);
            #0.1;
            if (aq.size() != 0) compare("async_reset", aq.pop_front());
        end
    end

    initial begin
        ir_reset = 1'b1;
        ir_wr    = 1'b0;
        ir_in    = 16'h2CB2;
        cyc(1, 0, 16'h2CB2);
        cyc(0, 1, 16'h2CB2);
        cyc(0, 0, 16'h2CB2);
        cyc(1, 0, 16'h2CB2);
        cyc(0, 0, 16'h2CB2);
        cyc(0, 0, 16'hF492);
        cyc(0, 1, 16'hF492);
        cyc(0, 0, 16'hF492);
        cyc(0, 0, 16'h0613);
        cyc(0, 0, 16'h110F);
        cyc(1, 1, 16'h110F);
        cyc(1, 1, 16'h110F);
        cyc(0, 1, 16'h110F);
        cyc(0, 0, 16'h110F);
        for (int i = 0; i < 400; i++)
            cyc(($urandom % 16) == 0, ($urandom % 3) == 0, 16'($urandom));
        ir_wr = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if (q.size() != 0 || aq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d edge and %0d reset expectations left, required 0", q.size(), aq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
